// File: rtl/vic_multi.sv
// Vectored interrupt controller: NIRQ sources, each level- or edge-triggered,
// fixed priority (trap first, then lowest source index), CPU register bank
// with combinational read and full-word-only writes.
module vic_multi #(
  parameter int NIRQ = 8,
  parameter int VW   = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic [4:0]      addr,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  output logic [31:0]     rdata,
  input  logic [NIRQ-1:0] src,
  input  logic            trap,
  output logic            irq,
  output logic [VW-1:0]   ivector
);

  localparam logic [4:0] ADDR_IRQEN   = 5'd0;
  localparam logic [4:0] ADDR_PEND    = 5'd1;
  localparam logic [4:0] ADDR_MODE    = 5'd2;
  localparam logic [4:0] ADDR_STATUS  = 5'd3;
  localparam logic [4:0] ADDR_TRAPVEC = 5'd4;

  logic            wr_en;
  logic [NIRQ-1:0] irqen_reg;
  logic [NIRQ-1:0] mode_reg;
  logic [NIRQ-1:0] epend_reg;
  logic [NIRQ-1:0] prev_reg;
  logic [NIRQ-1:0] mode_next;
  logic [NIRQ-1:0] epend_next;
  logic [NIRQ-1:0] w1c;
  logic [NIRQ-1:0] pend;
  logic [NIRQ-1:0] act;
  logic [NIRQ-1:0] vec_we;
  logic [VW-1:0]   trapvec_reg;
  logic [VW-1:0]   vec_reg [NIRQ];
  logic [3:0]      win_idx;
  logic [VW-1:0]   win_vec;
  logic            any_act;
  logic            unused_wdata;

  // Only a full-word strobe with chip select counts as a write
  assign wr_en = cs && (wstrb == 4'b1111);

  assign mode_next = (wr_en && addr == ADDR_MODE) ? wdata[NIRQ-1:0] : mode_reg;
  assign w1c       = (wr_en && addr == ADDR_PEND) ? wdata[NIRQ-1:0] : '0;

  // Level sources show the live line; edge sources show the stored bit
  assign pend    = (mode_reg & epend_reg) | (~mode_reg & src);
  assign act     = pend & irqen_reg;
  assign any_act = |act;

  // Bits of wdata outside the held fields are intentionally ignored
  assign unused_wdata = &{1'b0, wdata};

  genvar gi;
  generate
    for (gi = 0; gi < NIRQ; gi++) begin : g_src
      // The stored edge bit survives only while the source is edge mode both
      // before and after this edge, so a mode switch in either direction
      // leaves it cleared. A rising edge beats a coincident W1C.
      assign epend_next[gi] = mode_reg[gi] & mode_next[gi] &
                              ((src[gi] & ~prev_reg[gi]) |
                               (epend_reg[gi] & ~w1c[gi]));
      assign vec_we[gi] = wr_en && (addr == 5'(16 + gi));
    end
  endgenerate

  // Register bank, edge detector history and edge-pend storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqen_reg   <= '0;
      mode_reg    <= '0;
      epend_reg   <= '0;
      prev_reg    <= '0;
      trapvec_reg <= '0;
      for (int i = 0; i < NIRQ; i++) begin
        vec_reg[i] <= '0;
      end
    end else begin
      prev_reg  <= src;
      epend_reg <= epend_next;
      mode_reg  <= mode_next;
      if (wr_en && addr == ADDR_IRQEN) begin
        irqen_reg <= wdata[NIRQ-1:0];
      end
      if (wr_en && addr == ADDR_TRAPVEC) begin
        trapvec_reg <= wdata[VW+1:2];
      end
      for (int i = 0; i < NIRQ; i++) begin
        if (vec_we[i]) begin
          vec_reg[i] <= wdata[VW+1:2];
        end
      end
    end
  end

  // Fixed-priority winner: scan downward so the lowest active index wins
  always_comb begin
    win_idx = '0;
    win_vec = trapvec_reg;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (act[i]) begin
        win_idx = 4'(i);
        win_vec = vec_reg[i];
      end
    end
  end

  // CPU-facing request and vector; trap overrides every source
  always_comb begin
    irq     = any_act | trap;
    ivector = trapvec_reg;
    if (!trap && any_act) begin
      ivector = win_vec;
    end
  end

  // Register read mux; anything unimplemented reads as zero
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_IRQEN:   rdata[NIRQ-1:0] = irqen_reg;
      ADDR_PEND:    rdata[NIRQ-1:0] = pend;
      ADDR_MODE:    rdata[NIRQ-1:0] = mode_reg;
      ADDR_STATUS: begin
        rdata[31]  = any_act;
        rdata[3:0] = win_idx;
      end
      ADDR_TRAPVEC: rdata[VW+1:2] = trapvec_reg;
      default: begin
        for (int i = 0; i < NIRQ; i++) begin
          if (addr == 5'(16 + i)) begin
            rdata[VW+1:2] = vec_reg[i];
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_vic_multi.sv
// Self-checking bench for vic_multi: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the controller.
module tb_vic_multi;

  localparam int NIRQ = 8;
  localparam int VW   = 30;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            cs    = 1'b0;
  logic [4:0]      addr  = '0;
  logic [31:0]     wdata = '0;
  logic [3:0]      wstrb = '0;
  logic [NIRQ-1:0] src   = '0;
  logic            trap  = 1'b0;
  logic [31:0]     rdata;
  logic            irq;
  logic [VW-1:0]   ivector;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  vic_multi #(.NIRQ(NIRQ), .VW(VW)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .addr    (addr),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata),
    .src     (src),
    .trap    (trap),
    .irq     (irq),
    .ivector (ivector)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0]  m_en, m_mode, m_ep, m_prev;
  bit [29:0] m_tv;
  bit [29:0] m_vec [8];

  // Stored edge flag after this clock: kept only for sources that are edge
  // mode now and stay edge mode; set by a fresh rise, else held unless cleared.
  function automatic bit [7:0] model_next_ep();
    bit       wr;
    bit [7:0] new_mode;
    bit [7:0] r;
    wr       = cs && (wstrb == 4'hF);
    new_mode = (wr && addr == 5'd1 + 5'd1) ? wdata[7:0] : m_mode;
    r        = '0;
    for (int k = 0; k < 8; k++) begin
      bit rose;
      bit cleared;
      rose    = src[k] && !m_prev[k];
      cleared = wr && addr == 5'd1 && wdata[k];
      if (m_mode[k] == 1'b1 && new_mode[k] == 1'b1) begin
        if (rose)                      r[k] = 1'b1;
        else if (m_ep[k] && !cleared)  r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic bit [7:0] model_pend();
    bit [7:0] p;
    for (int k = 0; k < 8; k++) p[k] = m_mode[k] ? m_ep[k] : src[k];
    return p;
  endfunction

  function automatic int model_winner();
    bit [7:0] a;
    a = model_pend() & m_en;
    for (int k = 0; k < 8; k++) if (a[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] model_ivec();
    int w;
    w = model_winner();
    if (trap) return {2'b00, m_tv};
    if (w >= 0) return {2'b00, m_vec[w]};
    return {2'b00, m_tv};
  endfunction

  function automatic logic [31:0] model_rdata(input logic [4:0] a);
    int w;
    int ai;
    w  = model_winner();
    ai = int'(a);
    case (ai)
      0: return {24'b0, m_en};
      1: return {24'b0, model_pend()};
      2: return {24'b0, m_mode};
      3: return (w < 0) ? 32'h0 : (32'h8000_0000 | 32'(w));
      4: return {m_tv, 2'b00};
      default: begin
        if (ai >= 16 && ai < 16 + NIRQ) return {m_vec[ai-16], 2'b00};
        return 32'h0;
      end
    endcase
  endfunction

  // Model state update on the same events that update the DUT
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en   <= '0;
      m_mode <= '0;
      m_ep   <= '0;
      m_prev <= '0;
      m_tv   <= '0;
      for (int i = 0; i < 8; i++) m_vec[i] <= '0;
    end else begin
      m_ep   <= model_next_ep();
      m_prev <= src;
      if (cs && wstrb == 4'hF) begin
        if (addr == 5'd0) m_en   <= wdata[7:0];
        if (addr == 5'd2) m_mode <= wdata[7:0];
        if (addr == 5'd4) m_tv   <= wdata[31:2];
        if (addr >= 5'd16 && addr < 5'd24) m_vec[int'(addr) - 16] <= wdata[31:2];
      end
    end
  end

  // Compare process: outputs checked mid-cycle against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_irq",     {31'b0, irq},         {31'b0, (model_winner() >= 0) || trap});
      check("cyc_ivector", {2'b00, ivector},     model_ivec());
      check("cyc_rdata",   rdata,                model_rdata(addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    cs = 1'b1; addr = a; wdata = d; wstrb = s;
    sync();
    cs = 1'b0; wstrb = 4'b0000; wdata = '0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] expected);
    addr = a;
    #1;
    check(name, rdata, expected);
    sync();
  endtask

  initial begin
    // Reset state
    sync();
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_ivector", {2'b00, ivector}, 32'h0);
    addr = 5'd0;
    #1;
    check("rst_irqen", rdata, 32'h0);
    sync();
    reset = 1'b0;
    cmp_en = 1'b1;
    sync();

    // Level path
    wr_reg(5'd19, 32'h0000_0400, 4'hF);
    wr_reg(5'd0,  32'h08, 4'hF);
    wr_reg(5'd2,  32'h00, 4'hF);
    src[3] = 1'b1; addr = 5'd3;
    #1;
    check("lvl_irq", {31'b0, irq}, 32'h1);
    check("lvl_ivector", {2'b00, ivector}, 32'h100);
    check("lvl_status", rdata, 32'h8000_0003);
    sync();
    src[3] = 1'b0;
    #1;
    check("lvl_drop_irq", {31'b0, irq}, 32'h0);
    sync();

    // Edge path with W1C
    wr_reg(5'd2, 32'h01, 4'hF);
    wr_reg(5'd0, 32'h01, 4'hF);
    src[0] = 1'b1;
    #1;
    check("edge_not_yet", {31'b0, irq}, 32'h0);
    sync();
    src[0] = 1'b0;
    #1;
    check("edge_irq", {31'b0, irq}, 32'h1);
    sync();
    check("edge_held", {31'b0, irq}, 32'h1);
    sync();
    wr_reg(5'd1, 32'h01, 4'hF);
    check("edge_w1c", {31'b0, irq}, 32'h0);
    sync();

    // Set-wins collision on src[1]
    wr_reg(5'd2, 32'h02, 4'hF);
    cs = 1'b1; addr = 5'd1; wdata = 32'h02; wstrb = 4'hF; src[1] = 1'b1;
    sync();
    cs = 1'b0; wstrb = 4'h0; wdata = '0; src[1] = 1'b0;
    rd_chk("collision_pend", 5'd1, 32'h02);

    // Priority and trap
    wr_reg(5'd2,  32'h00, 4'hF);
    wr_reg(5'd0,  32'h24, 4'hF);
    wr_reg(5'd18, 32'h200, 4'hF);
    wr_reg(5'd21, 32'h500, 4'hF);
    src = 8'h24;
    #1;
    check("prio_ivector", {2'b00, ivector}, 32'h80);
    sync();
    wr_reg(5'd4, 32'h40, 4'hF);
    trap = 1'b1;
    #1;
    check("trap_ivector", {2'b00, ivector}, 32'h10);
    check("trap_irq", {31'b0, irq}, 32'h1);
    sync();
    trap = 1'b0; src = '0;
    sync();

    // Strobe and range checks
    wr_reg(5'd0, 32'hFF, 4'b0001);
    rd_chk("partial_strobe", 5'd0, 32'h24);
    wr_reg(5'd28, 32'h1234, 4'hF);
    rd_chk("vec12_unmapped", 5'd28, 32'h0);
    wr_reg(5'd4, 32'h43, 4'hF);
    rd_chk("trapvec_low_bits", 5'd4, 32'h40);

    // Reset mid-operation
    wr_reg(5'd2, 32'h05, 4'hF);
    wr_reg(5'd0, 32'hFF, 4'hF);
    src = 8'h05;
    sync();
    src = 8'h00;
    sync();
    rd_chk("pend_before_rst", 5'd1, 32'h05);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_irq", {31'b0, irq}, 32'h0);
    check("midrst_ivector", {2'b00, ivector}, 32'h0);
    sync();
    src = 8'h0F;
    sync();
    src = 8'h00;
    sync();
    reset = 1'b0;
    rd_chk("postrst_pend", 5'd1, 32'h0);
    rd_chk("postrst_irqen", 5'd0, 32'h0);

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NIRQ; k++) begin
        if ($urandom_range(0, 9) == 0) src[k] = ~src[k];
      end
      trap = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) < 4) addr = 5'($urandom_range(0, 4));
      else                          addr = 5'(16 + $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        cs    = 1'b1;
        wdata = $urandom;
        wstrb = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end else begin
        cs    = 1'($urandom_range(0, 1));
        wstrb = 4'h0;
      end
      sync();
    end
    cs = 1'b0; wstrb = 4'h0; reset = 1'b0; trap = 1'b0;
    sync();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
